// File: rtl/slave_port_initiator_pkg.sv
// Shared definitions for the slave-port initiator: default lane widths,
// legal access sizes and the 2-bit FSM state encoding.
package slave_port_initiator_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_SIZE_W = 7;

  localparam int SIZE_8  = 8;
  localparam int SIZE_16 = 16;
  localparam int SIZE_32 = 32;
  localparam int SIZE_64 = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic size_is_legal(input int unsigned size);
    return (size == SIZE_8) || (size == SIZE_16) ||
           (size == SIZE_32) || (size == SIZE_64);
  endfunction

  // Low address bits that must be zero for an access of this width.
  // Only meaningful for legal sizes.
  function automatic int unsigned size_align_mask(input int unsigned size);
    return (size / 8) - 1;
  endfunction

endpackage

// File: rtl/slave_port_initiator_timer.sv
// Request timer: counts cycles while enabled, flags the last allowed cycle.
module slave_req_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_reg;

  // expired is high during the TIMEOUT-th enabled cycle
  assign expired = (count_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/slave_port_initiator.sv
// Host-side initiator that turns single-beat commands into requests on one
// lane of the slave memory port of the HLS core, one transaction at a time.
module slave_port_initiator
  import slave_port_initiator_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int LANE     = 0,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SIZE_W   = DEF_SIZE_W,
  parameter int TIMEOUT  = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_we,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [SIZE_W-1:0]            cmd_size,
  input  logic [DATA_W-1:0]            cmd_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         busy,
  output logic [15:0]                  txn_count,
  output logic [CHANNELS-1:0]          S_oe_ram,
  output logic [CHANNELS-1:0]          S_we_ram,
  output logic [CHANNELS*ADDR_W-1:0]   S_addr_ram,
  output logic [CHANNELS*DATA_W-1:0]   S_Wdata_ram,
  output logic [CHANNELS*SIZE_W-1:0]   S_data_ram_size,
  input  logic [CHANNELS*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]          Sout_DataRdy
);

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [SIZE_W-1:0]   size_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                err_reg, err_next;
  logic [15:0]         txn_count_reg;

  logic                cmd_fire;
  logic                in_req;
  logic                cmd_legal;
  logic                timer_expired;
  logic                lane_rdy;
  logic [DATA_W-1:0]   lane_rdata;
  logic [DATA_W-1:0]   size_mask;
  logic                unused_lane_inputs;

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign in_req     = (state_reg == ST_REQ);
  assign lane_rdy   = Sout_DataRdy[LANE];
  assign lane_rdata = Sout_Rdata_ram[LANE*DATA_W +: DATA_W];

  // Other lanes' responses are deliberately ignored.
  assign unused_lane_inputs = ^{Sout_Rdata_ram, Sout_DataRdy};

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_mask
      assign size_mask[gi] = (32'(size_reg) > 32'(gi));
    end
  endgenerate

  assign cmd_legal = size_is_legal(32'(size_reg)) &&
                     ((addr_reg & ADDR_W'(size_align_mask(32'(size_reg)))) == '0);

  slave_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_req),
    .enable  (in_req),
    .expired (timer_expired)
  );

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    rdata_next = rdata_reg;
    cmd_ready  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = ST_CHECK;
          err_next   = 1'b0;
          rdata_next = '0;
        end
      end
      ST_CHECK: begin
        if (cmd_legal) begin
          state_next = ST_REQ;
        end else begin
          err_next   = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_REQ: begin
        // DataRdy wins over an expiring timer in the same cycle
        if (lane_rdy) begin
          err_next   = 1'b0;
          rdata_next = we_reg ? '0 : (lane_rdata & size_mask);
          state_next = ST_RESP;
        end else if (timer_expired) begin
          err_next   = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
      txn_count_reg <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      size_reg      <= '0;
      wdata_reg     <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      rdata_reg <= rdata_next;
      if (cmd_fire) begin
        we_reg    <= cmd_we;
        addr_reg  <= cmd_addr;
        size_reg  <= cmd_size;
        wdata_reg <= cmd_wdata;
      end
      if ((state_reg == ST_RESP) && !err_reg) begin
        txn_count_reg <= txn_count_reg + 16'd1;
      end
    end
  end

  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_err   = rsp_valid && err_reg;
  assign rsp_rdata = rdata_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign txn_count = txn_count_reg;

  // Only the selected lane carries the request; it is live only in REQ.
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      if (gi == LANE) begin : g_active
        assign S_oe_ram[gi] = in_req && !we_reg;
        assign S_we_ram[gi] = in_req && we_reg;
        assign S_addr_ram[gi*ADDR_W +: ADDR_W]      = in_req ? addr_reg : '0;
        assign S_Wdata_ram[gi*DATA_W +: DATA_W]     = in_req ? (wdata_reg & size_mask) : '0;
        assign S_data_ram_size[gi*SIZE_W +: SIZE_W] = in_req ? size_reg : '0;
      end else begin : g_idle
        assign S_oe_ram[gi] = 1'b0;
        assign S_we_ram[gi] = 1'b0;
        assign S_addr_ram[gi*ADDR_W +: ADDR_W]      = '0;
        assign S_Wdata_ram[gi*DATA_W +: DATA_W]     = '0;
        assign S_data_ram_size[gi*SIZE_W +: SIZE_W] = '0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_slave_port_initiator.sv
// Randomized bench for slave_port_initiator: a byte-memory responder on lane 0,
// noise on lane 1, and a command-level reference model of expected responses.
module tb_slave_port_initiator;

  localparam int CH  = 2;
  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int SW  = 7;
  localparam int TMO = 8;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_we;
  logic [AW-1:0]        cmd_addr;
  logic [SW-1:0]        cmd_size;
  logic [DW-1:0]        cmd_wdata;
  logic                 rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic                 busy;
  logic [15:0]          txn_count;
  logic [CH-1:0]        S_oe_ram;
  logic [CH-1:0]        S_we_ram;
  logic [CH*AW-1:0]     S_addr_ram;
  logic [CH*DW-1:0]     S_Wdata_ram;
  logic [CH*SW-1:0]     S_data_ram_size;
  logic [CH*DW-1:0]     Sout_Rdata_ram = '0;
  logic [CH-1:0]        Sout_DataRdy   = '0;

  always #5 clock = ~clock;

  slave_port_initiator #(
    .CHANNELS (CH),
    .LANE     (0),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .SIZE_W   (SW),
    .TIMEOUT  (TMO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_we          (cmd_we),
    .cmd_addr        (cmd_addr),
    .cmd_size        (cmd_size),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .busy            (busy),
    .txn_count       (txn_count),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // Responder state and captured request fields
  byte unsigned  resp_mem  [1024];
  byte unsigned  model_mem [1024];
  int            rdy_delay = 0;
  bit            noise_en  = 0;
  bit            ovr_en    = 0;
  logic [DW-1:0] ovr_data  = '0;
  int            act_cnt   = 0;
  int            req_cycles = 0;
  int            lane_bad  = 0;
  int            unstable  = 0;
  logic [AW-1:0] cap_addr, first_addr;
  logic [SW-1:0] cap_size, first_size;
  logic [DW-1:0] cap_wdata, first_wdata;
  logic          cap_oe, cap_we, first_oe;
  logic [15:0]   model_txn = '0;
  int            txn_id = 0;

  always @(posedge clock) begin
    #2;
    if (S_oe_ram[1] || S_we_ram[1] || (S_addr_ram[2*AW-1:AW] != '0) ||
        (S_Wdata_ram[2*DW-1:DW] != '0) || (S_data_ram_size[2*SW-1:SW] != '0))
      lane_bad++;
    Sout_Rdata_ram[2*DW-1:DW] = {$urandom, $urandom};
    Sout_DataRdy[1] = 1'($urandom_range(0, 1));
    if (S_oe_ram[0] || S_we_ram[0]) begin
      if (act_cnt == 0) begin
        first_addr  = S_addr_ram[AW-1:0];
        first_size  = S_data_ram_size[SW-1:0];
        first_wdata = S_Wdata_ram[DW-1:0];
        first_oe    = S_oe_ram[0];
      end else if (first_addr != S_addr_ram[AW-1:0] || first_size != S_data_ram_size[SW-1:0] ||
                   first_wdata != S_Wdata_ram[DW-1:0] || first_oe != S_oe_ram[0]) begin
        unstable++;
      end
      req_cycles++;
      if (act_cnt == rdy_delay) begin
        Sout_DataRdy[0] = 1'b1;
        cap_addr  = S_addr_ram[AW-1:0];
        cap_size  = S_data_ram_size[SW-1:0];
        cap_wdata = S_Wdata_ram[DW-1:0];
        cap_oe    = S_oe_ram[0];
        cap_we    = S_we_ram[0];
        if (S_we_ram[0]) begin
          for (int i = 0; i < int'(cap_size) / 8 && i < 8; i++)
            resp_mem[(int'(cap_addr) + i) % 1024] = cap_wdata[8*i +: 8];
          Sout_Rdata_ram[DW-1:0] = {$urandom, $urandom};
        end else if (ovr_en) begin
          Sout_Rdata_ram[DW-1:0] = ovr_data;
        end else begin
          for (int i = 0; i < 8; i++)
            Sout_Rdata_ram[8*i +: 8] = resp_mem[(int'(cap_addr) + i) % 1024];
        end
      end else begin
        Sout_DataRdy[0] = 1'b0;
        Sout_Rdata_ram[DW-1:0] = {$urandom, $urandom};
      end
      act_cnt++;
    end else begin
      act_cnt = 0;
      Sout_DataRdy[0] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      Sout_Rdata_ram[DW-1:0] = {$urandom, $urandom};
    end
  end

  function automatic bit model_legal(input logic [AW-1:0] a, input logic [SW-1:0] s);
    int sz;
    sz = int'(s);
    if (!(sz == 8 || sz == 16 || sz == 32 || sz == 64)) return 1'b0;
    return (int'(a) % (sz / 8)) == 0;
  endfunction

  function automatic logic [63:0] model_mask(input logic [SW-1:0] s);
    if (int'(s) >= 64) return '1;
    return (64'd1 << s) - 64'd1;
  endfunction

  function automatic logic [63:0] model_read(input logic [AW-1:0] a, input logic [SW-1:0] s);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < int'(s) / 8; i++) v[8*i +: 8] = model_mem[(int'(a) + i) % 1024];
    return v;
  endfunction

  // Issue one command (called and returning at a negedge) and check its response.
  task automatic do_cmd(input bit we, input logic [AW-1:0] addr, input logic [SW-1:0] size,
                        input logic [DW-1:0] wdata, input int delay);
    int lat, waited, exp_lat, exp_req;
    bit exp_err;
    logic [DW-1:0] exp_rdata, mask;
    mask = model_mask(size);
    if (!model_legal(addr, size)) begin
      exp_err = 1'b1; exp_lat = 2; exp_req = 0;
    end else if (delay < 0 || delay >= TMO) begin
      exp_err = 1'b1; exp_lat = 2 + TMO; exp_req = TMO;
    end else begin
      exp_err = 1'b0; exp_lat = 3 + delay; exp_req = delay + 1;
    end
    exp_rdata = '0;
    if (!exp_err && !we) exp_rdata = ovr_en ? (ovr_data & mask) : model_read(addr, size);
    rdy_delay = delay;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
    waited = 0;
    while (!cmd_ready && waited < 20) begin @(negedge clock); waited++; end
    if (!cmd_ready) begin
      check("cmd_accept", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    req_cycles = 0;
    @(negedge clock);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 3 * TMO + 20) begin @(negedge clock); lat++; end
    txn_id++;
    $display("txn %0d we=%0d addr=0x%03h size=%0d delay=%0d err=%0d rdata=0x%016h lat=%0d",
             txn_id, we, addr, size, delay, rsp_err, rsp_rdata, lat);
    check("rsp_latency", 64'(lat), 64'(exp_lat));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("busy_in_resp", 64'(busy), 64'd1);
    check("ready_in_resp", 64'(cmd_ready), 64'd0);
    check("req_cycles", 64'(req_cycles), 64'(exp_req));
    if (!exp_err) begin
      check("s_addr", 64'(cap_addr), 64'(addr));
      check("s_size", 64'(cap_size), 64'(size));
      check("s_dir", 64'({cap_we, cap_oe}), we ? 64'd2 : 64'd1);
      if (we) begin
        check("s_wdata", cap_wdata, wdata & mask);
        for (int i = 0; i < int'(size) / 8; i++)
          model_mem[(int'(addr) + i) % 1024] = wdata[8*i +: 8];
      end
      model_txn = model_txn + 16'd1;
    end
    @(negedge clock);
    check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    check("ready_after", 64'(cmd_ready), 64'd1);
    check("txn_count", 64'(txn_count), 64'(model_txn));
  endtask

  initial begin
    int sz_tab[4];
    int ill_tab[3];
    int r, waited;
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    logic [7:0] bytes_w [16];
    sz_tab  = '{8, 16, 32, 64};
    ill_tab = '{24, 0, 127};
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      resp_mem[i]  = 8'($urandom);
      model_mem[i] = resp_mem[i];
    end
    repeat (3) @(negedge clock);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_txn", 64'(txn_count), 64'd0);
    check("rst_s_out", 64'({S_oe_ram, S_we_ram, |S_addr_ram, |S_Wdata_ram, |S_data_ram_size}), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    do_cmd(1'b1, 10'h010, 7'd32, 64'hDEADBEEF_CAFEF00D, 1);
    check("t1_wdata", cap_wdata, 64'h00000000_CAFEF00D);
    check("t1_txn", 64'(txn_count), 64'd1);

    ovr_en = 1'b1; ovr_data = 64'h1234_5678_9ABC_DEF0;
    do_cmd(1'b0, 10'h010, 7'd16, 64'd0, 2);
    check("t2_rdata", rsp_rdata, 64'h0000_0000_0000_DEF0);
    ovr_en = 1'b0;

    do_cmd(1'b0, 10'h003, 7'd32, 64'd0, 0);
    check("t3_txn", 64'(txn_count), 64'd2);

    do_cmd(1'b0, 10'h020, 7'd64, 64'd0, -1);
    do_cmd(1'b0, 10'h020, 7'd64, 64'd0, 0);
    do_cmd(1'b0, 10'h028, 7'd64, 64'd0, TMO - 1);
    do_cmd(1'b1, 10'h030, 7'd64, 64'hFFFF_0000_1111_2222, TMO);

    noise_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      s = (r < 8) ? 7'(sz_tab[r % 4]) : 7'(ill_tab[$urandom_range(0, 2)]);
      a = 10'($urandom);
      if ($urandom_range(0, 3) != 0 && r < 8) a = a & ~10'(sz_tab[r % 4] / 8 - 1);
      r = $urandom_range(0, 9);
      do_cmd(1'($urandom_range(0, 1)), a, s, {$urandom, $urandom},
             (r < 7) ? (r % 4) : (r == 7) ? TMO - 1 : (r == 8) ? TMO : -1);
    end
    noise_en = 1'b0;

    // Reset while the request is on the bus
    rdy_delay = -1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h040; cmd_size = 7'd64;
    waited = 0;
    while (!cmd_ready && waited < 20) begin @(negedge clock); waited++; end
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    check("t5_oe_in_req", 64'(S_oe_ram[0]), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("t5_s_out", 64'({S_oe_ram, S_we_ram, |S_addr_ram, |S_Wdata_ram, |S_data_ram_size}), 64'd0);
    check("t5_valid", 64'(rsp_valid), 64'd0);
    check("t5_ready", 64'(cmd_ready), 64'd1);
    check("t5_txn", 64'(txn_count), 64'd0);
    reset = 1'b0;
    model_txn = '0;
    @(negedge clock);
    check("t5_no_rsp", 64'(rsp_valid), 64'd0);

    // Preload then read back a block of bytes
    for (int i = 0; i < 16; i++) begin
      bytes_w[i] = 8'($urandom);
      do_cmd(1'b1, 10'(10'h100 + i), 7'd8, {56'($urandom), bytes_w[i]}, $urandom_range(0, 2));
    end
    for (int i = 0; i < 16; i++) begin
      do_cmd(1'b0, 10'(10'h100 + i), 7'd8, 64'd0, $urandom_range(0, 2));
      check("t6_readback", rsp_rdata, 64'(bytes_w[i]));
    end
    check("t6_txn", 64'(txn_count), 64'd32);

    check("lane1_idle", 64'(lane_bad), 64'd0);
    check("req_stable", 64'(unstable), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
